seq_ctrl: RTL
=============

# seq_ctrl

Parametrised sequencer for the register-file/RAM recurrence datapath: drives the register-file read addresses, write-back address and write enable, plus the result-RAM write enable and address, to generate an N-term recurrence such as Fibonacci. It generalises the fixed 6-bit, fixed-length controller in four ways:
- address width is a parameter;
- sequence length is set at run time;
- a recurrence mode is selectable;
- an explicit start/busy/done handshake is added.

It sits between the top-level button/switch logic and the register file + ALU + distributed RAM.

## Interface
- AW, 6, address width of register file and RAM (depth 2^AW)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin sequence; sampled only in IDLE
- len  in  AW  number of terms to produce; latched on accepted start
- mode  in  1  0 = two-term (x[k]=f(x[k-2],x[k-1])), 1 = one-term (x[k]=f(x[k-1],x[k-1])); latched on accepted start
- wer  out  1  register-file write enable
- seed_sel  out  1  1 = register file writes external seed, 0 = ALU result
- addr1  out  AW  register-file read port A address
- addr2  out  AW  register-file read port B address
- addr3  out  AW  register-file write address
- wea  out  1  RAM write enable
- addr_ram  out  AW  RAM write address
- clr  out  1  clear-phase write (only with SEQ_CLEAR_EN)
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLEAR (macro only), SEED0, SEED1, RUN, DONE; 3-bit state register; AW-bit term counter k.
- All outputs are registered; values below hold during the cycle the FSM is in that state.
- IDLE:
  - wer=0, clr=0, busy=0.
  - start=1 latches len_q=max(len,2) and mode_q, then goes to CLEAR if compiled in, else to SEED0.
- SEED0: wer=1, seed_sel=1, addr3=0 -> SEED1.
- SEED1: wer=1, seed_sel=1, addr3=1; k<=2.
  - If len_q==2 -> DONE, else -> RUN.
- RUN:
  - Outputs: wer=1, seed_sel=0, addr3=k, addr2=k-1.
  - addr1=k-2 when mode_q=0, addr1=k-1 when mode_q=1.
  - k increments each cycle; when k==len_q-1 -> DONE.
- DONE: wer=0, done=1 for exactly one cycle -> IDLE.
- busy=1 in every state except IDLE.
- RAM path:
  - wea and addr_ram are wer and addr3 delayed one cycle, so each RAM write captures the value just written back to the register file.
  - Clear-phase writes never produce wea.
- start while busy is ignored; len and mode changes while busy have no effect.
- Address arithmetic is modulo 2^AW; max term count is 2^AW-1 (len=all-ones writes addresses 0..2^AW-2).

## Timing
- Reset (async, any state): state=IDLE, k=0, wer=0, wea=0, seed_sel=0, clr=0, busy=0, done=0, addr1=0, addr2=1, addr3=0, addr_ram=0. Any sequence in progress is abandoned; no further writes.
- Start accepted at edge E0:
  - SEED0 holds for E0..E1.
  - First RUN cycle begins at E2.
- Without the macro:
  - busy is high for len_q+1 cycles.
  - Final wea coincides with the DONE cycle.
- Latency from start to the done pulse is len_q cycles; done and the final wea are asserted together.
- A start asserted in the cycle after DONE (FSM back in IDLE) is accepted; no dead cycle.
- len 0 or 1 is clamped to 2: seeds only, then DONE.

## Configuration
- SEQ_CLEAR_EN:
  - Defined: CLEAR state is inserted before SEED0. For 2^AW cycles addr3 walks 0..2^AW-1 with wer=1, clr=1, seed_sel=0, wea=0; the register file writes zero while clr=1. busy length grows by 2^AW.
  - Undefined: no CLEAR state; clr is tied 0; the register file keeps prior contents.

## Test plan
- Reset mid-RUN (k=5, AW=6) -> next cycle wer=0, wea=0, busy=0, addr2=1; no further writes; a new start works normally.
- len=10, mode=0, no macro, seeds 1 and 1 -> wer high 10 cycles; addr3 sequence 0..9; RUN addr1/addr2 pairs (0,1)..(7,8); RAM[0..9]=1,1,2,3,5,8,13,21,34,55; done pulse 10 cycles after start; busy high 11 cycles.
- len=6, mode=1, seeds 1, 2, ALU=add -> addr1=addr2=k-1 in RUN; RAM[0..5]=1,2,4,8,16,32.
- len=0 and len=1 -> exactly two seed writes (addr3=0,1); done 2 cycles after start.
- start held high through a whole run, then re-pulsed during RUN -> second start ignored; held start re-accepted in the first IDLE cycle after DONE.
- SEQ_CLEAR_EN, AW=4, len=3 -> 16 clr cycles over addr3=0..15 with wea=0, then SEED0/SEED1/RUN; busy high 20 cycles.

Source files
------------

// File: rtl/seq_ctrl.sv
// Sequencer for the register-file/RAM recurrence datapath (seeds, then x[k]=f(...)).
// Optional clear phase before seeding is compiled in with `define SEQ_CLEAR_EN.
module seq_ctrl #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic          mode,
    output logic          wer,
    output logic          seed_sel,
    output logic [AW-1:0] addr1,
    output logic [AW-1:0] addr2,
    output logic [AW-1:0] addr3,
    output logic          wea,
    output logic [AW-1:0] addr_ram,
    output logic          clr,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef SEQ_CLEAR_EN
    localparam logic [2:0] S_CLEAR = 3'd1;
`endif
    localparam logic [2:0] S_SEED0 = 3'd2;
    localparam logic [2:0] S_SEED1 = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] TWO  = AW'(2);
    localparam logic [AW-1:0] ALL1 = '1;

    logic [2:0]    state, state_n;
    logic [AW-1:0] k, k_n, len_q, len_n;
    logic [AW-1:0] a1_n, a2_n, a3_n;
    logic          mode_q, mode_n, wer_n, seed_n;

    // Next state and the output values that belong to that next state, so
    // every output is registered yet valid for the whole state cycle.
    always_comb begin
        state_n = state;
        k_n     = k;
        len_n   = len_q;
        mode_n  = mode_q;
        wer_n   = 1'b0;
        seed_n  = 1'b0;
        a1_n    = addr1;
        a2_n    = addr2;
        a3_n    = addr3;
        case (state)
            S_IDLE: begin
                if (start) begin
                    len_n  = (len < TWO) ? TWO : len;
                    mode_n = mode;
                    wer_n  = 1'b1;
                    a3_n   = '0;
`ifdef SEQ_CLEAR_EN
                    state_n = S_CLEAR;
`else
                    state_n = S_SEED0;
                    seed_n  = 1'b1;
`endif
                end
            end
`ifdef SEQ_CLEAR_EN
            S_CLEAR: begin
                wer_n = 1'b1;
                if (addr3 == ALL1) begin
                    state_n = S_SEED0;
                    seed_n  = 1'b1;
                    a3_n    = '0;
                end else begin
                    a3_n = addr3 + ONE;
                end
            end
`endif
            S_SEED0: begin
                state_n = S_SEED1;
                wer_n   = 1'b1;
                seed_n  = 1'b1;
                a3_n    = ONE;
                k_n     = TWO;
            end
            S_SEED1: begin
                if (len_q == TWO) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_RUN;
                    wer_n   = 1'b1;
                    a3_n    = k;
                    a2_n    = k - ONE;
                    a1_n    = mode_q ? (k - ONE) : (k - TWO);
                end
            end
            S_RUN: begin
                if (k == len_q - ONE) begin
                    state_n = S_DONE;
                end else begin
                    k_n   = k + ONE;
                    wer_n = 1'b1;
                    a3_n  = k + ONE;
                    a2_n  = k;
                    a1_n  = mode_q ? k : (k - ONE);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            k        <= '0;
            len_q    <= TWO;
            mode_q   <= 1'b0;
            wer      <= 1'b0;
            seed_sel <= 1'b0;
            addr1    <= '0;
            addr2    <= ONE;
            addr3    <= '0;
            wea      <= 1'b0;
            addr_ram <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            len_q    <= len_n;
            mode_q   <= mode_n;
            wer      <= wer_n;
            seed_sel <= seed_n;
            addr1    <= a1_n;
            addr2    <= a2_n;
            addr3    <= a3_n;
            // RAM captures last cycle's register-file write; clear writes never reach it
            wea      <= wer & ~clr;
            addr_ram <= addr3;
            busy     <= (state_n != S_IDLE);
            done     <= (state_n == S_DONE);
        end
    end

`ifdef SEQ_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) clr <= 1'b0;
        else     clr <= (state_n == S_CLEAR);
    end
`else
    assign clr = 1'b0;
`endif

endmodule
